// File: rtl/fclass_pkg.sv
// Shared definitions for the pipelined FCLASS unit: class-bit indices and the
// decoded-field record carried from stage 1 to stage 2.
package fclass_pkg;

    localparam int unsigned FCLASS_W        = 10;

    localparam int unsigned FCLASS_NEG_INF  = 0;
    localparam int unsigned FCLASS_NEG_NORM = 1;
    localparam int unsigned FCLASS_NEG_SUB  = 2;
    localparam int unsigned FCLASS_NEG_ZERO = 3;
    localparam int unsigned FCLASS_POS_ZERO = 4;
    localparam int unsigned FCLASS_POS_SUB  = 5;
    localparam int unsigned FCLASS_POS_NORM = 6;
    localparam int unsigned FCLASS_POS_INF  = 7;
    localparam int unsigned FCLASS_SNAN     = 8;
    localparam int unsigned FCLASS_QNAN     = 9;

    typedef struct packed {
        logic sign;
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        logic man_msb;
        logic boxed_ok;
    } fclass_fields_t;

endpackage

// File: rtl/fclass_encode.sv
// Combinational decoded-fields to one-hot FCLASS mask. A failed NaN-box check
// overrides everything and reports the canonical quiet NaN.
module fclass_encode
    import fclass_pkg::*;
(
    input  fclass_fields_t        f_i,
    output logic [FCLASS_W-1:0]   mask_o
);

    always_comb begin
        mask_o = '0;
        if (!f_i.boxed_ok) begin
            mask_o[FCLASS_QNAN] = 1'b1;
        end else if (f_i.exp_ones) begin
            if (!f_i.man_zero) begin
                if (f_i.man_msb) begin
                    mask_o[FCLASS_QNAN] = 1'b1;
                end else begin
                    mask_o[FCLASS_SNAN] = 1'b1;
                end
            end else if (f_i.sign) begin
                mask_o[FCLASS_NEG_INF] = 1'b1;
            end else begin
                mask_o[FCLASS_POS_INF] = 1'b1;
            end
        end else if (f_i.exp_zero) begin
            if (f_i.man_zero) begin
                if (f_i.sign) begin
                    mask_o[FCLASS_NEG_ZERO] = 1'b1;
                end else begin
                    mask_o[FCLASS_POS_ZERO] = 1'b1;
                end
            end else if (f_i.sign) begin
                mask_o[FCLASS_NEG_SUB] = 1'b1;
            end else begin
                mask_o[FCLASS_POS_SUB] = 1'b1;
            end
        end else if (f_i.sign) begin
            mask_o[FCLASS_NEG_NORM] = 1'b1;
        end else begin
            mask_o[FCLASS_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fclass_pipe.sv
// Two-stage valid/ready FCLASS unit for a parametrised IEEE-754 format.
// Optional NaN-box checking of upper operand bits: define FCLASS_NANBOX_EN.
module fclass_pipe
    import fclass_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned IN_W  = 32,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_a,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_class,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned FW = 1 + EXP_W + MAN_W;

    logic                 s1_valid_q, s1_valid_d;
    fclass_fields_t       s1_f_q, s1_f_d;
    logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [FCLASS_W-1:0]  s2_mask_q, s2_mask_d;
    logic [TAG_W-1:0]     s2_tag_q, s2_tag_d;

    logic                 s1_en, s2_en;
    logic                 boxed_ok;
    logic [EXP_W-1:0]     exp_f;
    logic [MAN_W-1:0]     man_f;
    logic [FCLASS_W-1:0]  enc_mask;

    assign exp_f = in_a[FW-2:MAN_W];
    assign man_f = in_a[MAN_W-1:0];

`ifdef FCLASS_NANBOX_EN
    if (IN_W > FW) begin : g_box
        assign boxed_ok = &in_a[IN_W-1:FW];
    end else begin : g_nobox
        assign boxed_ok = 1'b1;
    end
`else
    // Upper operand bits are deliberately ignored in this build.
    if (IN_W > FW) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^in_a[IN_W-1:FW];
    end
    assign boxed_ok = 1'b1;
`endif

    fclass_encode u_encode (
        .f_i    (s1_f_q),
        .mask_o (enc_mask)
    );

    always_comb begin
        s2_en      = !s2_valid_q || out_ready;
        s1_en      = !s1_valid_q || s2_en;

        s1_valid_d = s1_valid_q;
        s1_f_d     = s1_f_q;
        s1_tag_d   = s1_tag_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_f_d.sign     = in_a[FW-1];
                s1_f_d.exp_ones = &exp_f;
                s1_f_d.exp_zero = ~|exp_f;
                s1_f_d.man_zero = ~|man_f;
                s1_f_d.man_msb  = man_f[MAN_W-1];
                s1_f_d.boxed_ok = boxed_ok;
                s1_tag_d        = in_tag;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_mask_d  = s2_mask_q;
        s2_tag_d   = s2_tag_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mask_d = enc_mask;
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_f_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mask_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_f_q     <= s1_f_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_mask_q  <= s2_mask_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign in_ready  = s1_en;
    assign out_valid = s2_valid_q;
    assign out_tag   = s2_tag_q;

    always_comb begin
        out_class                 = '0;
        out_class[FCLASS_W-1:0]   = s2_mask_q;
    end

endmodule

// File: tb/tb_fclass_pipe.sv
// Directed and random checks of fclass_pipe: single-precision stream with and
// without backpressure, reset flush, a binary64 build and a 64-bit NaN-box build.
module tb_fclass_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, out_class;
    logic [4:0]  in_tag, out_tag;

    logic        w_valid, w_ready, w_ovalid;
    logic [63:0] w_a, w_class;
    logic [4:0]  w_tag, w_otag;

    logic        n_valid, n_ready, n_ovalid;
    logic [63:0] n_a;
    logic [31:0] n_class;
    logic [4:0]  n_tag, n_otag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] st_a   [64];
    logic [4:0]  st_tag [64];
    logic [31:0] st_exp [64];

    fclass_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_tag   (out_tag)
    );

    fclass_pipe #(.EXP_W(11), .MAN_W(52), .IN_W(64), .XLEN(64), .TAG_W(5)) u_d64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_valid),
        .in_ready  (w_ready),
        .in_a      (w_a),
        .in_tag    (w_tag),
        .out_valid (w_ovalid),
        .out_ready (1'b1),
        .out_class (w_class),
        .out_tag   (w_otag)
    );

    fclass_pipe #(.EXP_W(8), .MAN_W(23), .IN_W(64), .XLEN(32), .TAG_W(5)) u_box (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n_valid),
        .in_ready  (n_ready),
        .in_a      (n_a),
        .in_tag    (n_tag),
        .out_valid (n_ovalid),
        .out_ready (1'b1),
        .out_class (n_class),
        .out_tag   (n_otag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_class(input logic [31:0] x);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = x[31];
        e = x[30:23];
        m = x[22:0];
        if (e == 8'hff) begin
            if (m == '0) return s ? 32'h001 : 32'h080;
            return m[22] ? 32'h200 : 32'h100;
        end
        if (e == 8'h00) begin
            if (m == '0) return s ? 32'h008 : 32'h010;
            return s ? 32'h004 : 32'h020;
        end
        return s ? 32'h002 : 32'h040;
    endfunction

    // Streams n operands from st_* while popping results; out_ready follows a
    // fixed stall window or a random pattern.
    task automatic stream(input int n, input bit rnd, input int st0, input int stn,
                          output int first_pres, output int first_val,
                          output int last_val, output int stall_acc);
        int          tx, rx, it;
        bit          hold;
        logic [31:0] h_class;
        logic [4:0]  h_tag;
        tx = 0; rx = 0; it = 0; hold = 1'b0;
        h_class = '0; h_tag = '0;
        first_pres = -1; first_val = -1; last_val = -1; stall_acc = 0;
        while (rx < n && it < 500) begin
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_class", 64'(out_class), 64'(h_class));
                chk("hold_tag", 64'(out_tag), 64'(h_tag));
            end
            if (out_valid && first_val < 0) first_val = it;
            if (rnd) out_ready = ($urandom_range(0, 1) != 0);
            else     out_ready = !(it >= st0 && it < st0 + stn);
            in_valid = (tx < n);
            if (tx < n) begin
                in_a   = st_a[tx];
                in_tag = st_tag[tx];
            end
            #1;
            if (out_valid && out_ready) begin
                chk("class", 64'(out_class), 64'(st_exp[rx]));
                chk("tag", 64'(out_tag), 64'(st_tag[rx]));
                chk("hi_zero", 64'(out_class[31:10]), 64'd0);
                chk("onehot", 64'($countones(out_class)), 64'd1);
                rx++;
                last_val = it;
            end
            if (in_valid && in_ready) begin
                if (first_pres < 0) first_pres = it;
                if (!out_ready) stall_acc++;
                tx++;
            end
            hold    = out_valid && !out_ready;
            h_class = out_class;
            h_tag   = out_tag;
            @(posedge clk); #1;
            it++;
        end
        chk("stream_done", 64'(rx), 64'(n));
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [63:0] w_tv_a [4];
        logic [63:0] w_tv_exp [4];
        logic [63:0] n_tv_a [2];
        logic [63:0] n_tv_exp [2];
        logic [31:0] r;
        logic [7:0]  e;
        logic [22:0] m;
        int          fp, fv, lv, sa;

        tbl[0] = '{32'hff800000, 5'd0, 32'h001};
        tbl[1] = '{32'h90000200, 5'd1, 32'h002};
        tbl[2] = '{32'h80000200, 5'd2, 32'h004};
        tbl[3] = '{32'h80000000, 5'd3, 32'h008};
        tbl[4] = '{32'h00000000, 5'd4, 32'h010};
        tbl[5] = '{32'h00000200, 5'd5, 32'h020};
        tbl[6] = '{32'h10000200, 5'd6, 32'h040};
        tbl[7] = '{32'h7f800000, 5'd7, 32'h080};
        tbl[8] = '{32'h7fa00000, 5'd8, 32'h100};
        tbl[9] = '{32'h7fc00000, 5'd9, 32'h200};

        w_tv_a[0] = 64'h7ff8000000000000;  w_tv_exp[0] = 64'h200;
        w_tv_a[1] = 64'h7ff0000000000001;  w_tv_exp[1] = 64'h100;
        w_tv_a[2] = 64'h8000000000000001;  w_tv_exp[2] = 64'h004;
        w_tv_a[3] = 64'hfff0000000000000;  w_tv_exp[3] = 64'h001;

        n_tv_a[0] = 64'hffffffff3f800000; n_tv_exp[0] = 64'h040;
        n_tv_a[1] = 64'h000000003f800000;
`ifdef FCLASS_NANBOX_EN
        n_tv_exp[1] = 64'h200;
`else
        n_tv_exp[1] = 64'h040;
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_tag = '0;
        w_valid = 1'b0; w_a = '0; w_tag = '0;
        n_valid = 1'b0; n_a = '0; n_tag = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_class", 64'(out_class), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            st_a[i]   = tbl[i].a;
            st_tag[i] = tbl[i].tag;
            st_exp[i] = tbl[i].exp;
        end
        stream(10, 1'b0, 0, 0, fp, fv, lv, sa);
        chk("latency", 64'(fv - fp), 64'd2);
        chk("throughput", 64'(lv - fp), 64'd11);

        stream(10, 1'b0, 0, 5, fp, fv, lv, sa);
        chk("stall_accepts", 64'(sa), 64'd2);

        in_valid = 1'b1; in_a = 32'h3f800000; in_tag = 5'd21;
        @(posedge clk); #1;
        in_a = 32'hbf800000; in_tag = 5'd22;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre_rst_inflight", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_class", 64'(out_class), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_stale", 64'(out_valid), 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       e = 8'h00;
                1:       e = 8'hff;
                default: e = r[30:23];
            endcase
            m = ($urandom_range(0, 2) == 0) ? '0 : r[22:0];
            st_a[i]   = {r[31], e, m};
            st_tag[i] = 5'(i);
            st_exp[i] = ref_class(st_a[i]);
        end
        stream(40, 1'b1, 0, 0, fp, fv, lv, sa);

        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1; w_a = w_tv_a[i]; w_tag = 5'(i + 3);
            @(posedge clk); #1;
            w_valid = 1'b0;
            @(posedge clk); #1;
            chk("d64_valid", 64'(w_ovalid), 64'd1);
            chk("d64_class", w_class, w_tv_exp[i]);
            chk("d64_tag", 64'(w_otag), 64'(i + 3));
        end

        for (int i = 0; i < 2; i++) begin
            n_valid = 1'b1; n_a = n_tv_a[i]; n_tag = 5'(i + 17);
            @(posedge clk); #1;
            n_valid = 1'b0;
            @(posedge clk); #1;
            chk("box_valid", 64'(n_ovalid), 64'd1);
            chk("box_class", 64'(n_class), n_tv_exp[i]);
            chk("box_tag", 64'(n_otag), 64'(i + 17));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
